// File: rtl/note_judge.sv
// Hit-window timing judge for one rhythm-game lane.
// Grades one button press per note as perfect/good, or reports a miss.
module note_judge #(
    parameter int WIN_TICKS  = 8,
    parameter int PERF_TICKS = 2,
    parameter int CNT_W      = 6
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Tick,
    input  logic             i_NoteOpen,
    input  logic             i_Btn,
    output logic             o_Hit,
    output logic             o_Miss,
    output logic             o_Perfect,
    output logic [CNT_W-1:0] o_Offset,
    output logic             o_Busy
);

    typedef enum logic {
        IDLE,
        OPEN
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * WIN_TICKS);
    localparam logic [CNT_W-1:0] MID  = CNT_W'(WIN_TICKS);
    localparam logic [CNT_W-1:0] PERF = CNT_W'(PERF_TICKS);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             btn_s1, btn_s2, btn_prev;
    logic             press;
    logic             hit_n, miss_n, perf_n;
    logic [CNT_W-1:0] off_n;
    logic [CNT_W-1:0] diff, mag;

    assign press = btn_s2 & ~btn_prev;
    assign diff  = cnt - MID;
    assign mag   = diff[CNT_W-1] ? (~diff + 1'b1) : diff;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_prev  <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            o_Hit     <= 1'b0;
            o_Miss    <= 1'b0;
            o_Perfect <= 1'b0;
            o_Offset  <= '0;
            o_Busy    <= 1'b0;
        end else begin
            btn_s1    <= i_Btn;
            btn_s2    <= btn_s1;
            btn_prev  <= btn_s2;
            state     <= state_n;
            cnt       <= cnt_n;
            o_Hit     <= hit_n;
            o_Miss    <= miss_n;
            o_Perfect <= perf_n;
            o_Offset  <= off_n;
            o_Busy    <= (state_n == OPEN);
        end
    end

    // Press beats expiry beats re-open; a coincident NoteOpen restarts the window.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        perf_n  = 1'b0;
        off_n   = o_Offset;
        unique case (state)
            IDLE: begin
                if (i_NoteOpen) begin
                    state_n = OPEN;
                    cnt_n   = '0;
                end
            end
            OPEN: begin
                if (press) begin
                    hit_n   = 1'b1;
                    perf_n  = (mag <= PERF);
                    off_n   = diff;
                    cnt_n   = '0;
                    state_n = i_NoteOpen ? OPEN : IDLE;
                end else if (i_Tick && cnt == LAST) begin
                    miss_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = i_NoteOpen ? OPEN : IDLE;
                end else if (i_NoteOpen) begin
                    miss_n = 1'b1;
                    cnt_n  = '0;
                end else if (i_Tick) begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: directed scenarios then random traffic,
// all checked every cycle against a note-level behavioural model.
module tb_note_judge;

    localparam int WIN  = 8;
    localparam int PERF = 2;
    localparam int CW   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0;
    logic          note = 1'b0;
    logic          btn = 1'b0;
    logic          hit, miss, perfect, busy;
    logic [CW-1:0] offset;

    int n_cmp = 0;
    int n_err = 0;

    // model state: button seen 1/2/3 edges ago, window open, ticks since open
    bit m_b1, m_b2, m_b3;
    bit m_open;
    int m_t;
    bit e_hit, e_miss, e_perf;
    int e_off;

    note_judge #(
        .WIN_TICKS (WIN),
        .PERF_TICKS(PERF),
        .CNT_W     (CW)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Tick    (tick),
        .i_NoteOpen(note),
        .i_Btn     (btn),
        .o_Hit     (hit),
        .o_Miss    (miss),
        .o_Perfect (perfect),
        .o_Offset  (offset),
        .o_Busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_b1 = 0; m_b2 = 0; m_b3 = 0;
        m_open = 0; m_t = 0;
        e_hit = 0; e_miss = 0; e_perf = 0; e_off = 0;
    endtask

    task automatic model_edge(input bit n, input bit t, input bit b);
        bit pr;
        int a;
        pr = m_b2 && !m_b3;
        m_b3 = m_b2; m_b2 = m_b1; m_b1 = b;
        e_hit = 0; e_miss = 0;
        if (!m_open) begin
            if (n) begin m_open = 1; m_t = 0; end
        end else if (pr) begin
            e_hit = 1; e_off = m_t - WIN; m_open = n; m_t = 0;
        end else if (t && m_t == 2 * WIN) begin
            e_miss = 1; m_open = n; m_t = 0;
        end else if (n) begin
            e_miss = 1; m_t = 0;
        end else if (t) begin
            m_t++;
        end
        a = (e_off < 0) ? -e_off : e_off;
        e_perf = e_hit && (a <= PERF);
    endtask

    task automatic check_all();
        logic [CW-1:0] eo;
        eo = e_off[CW-1:0];
        chk("hit", int'(hit), int'(e_hit));
        chk("miss", int'(miss), int'(e_miss));
        chk("perfect", int'(perfect), int'(e_perf));
        chk("offset", int'(offset), int'(eo));
        chk("busy", int'(busy), int'(m_open));
    endtask

    task automatic step(input bit n, input bit t, input bit b);
        note = n; tick = t; btn = b;
        @(posedge clk);
        model_edge(n, t, b);
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int k, input bit b);
        for (int i = 0; i < k; i++) step(0, 1, b);
    endtask

    task automatic wait_hit(input string tag, input int off, input int pf);
        logic [CW-1:0] eo;
        eo = off[CW-1:0];
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            if (hit) break;
        end
        chk({tag, "_hit"}, int'(hit), 1);
        chk({tag, "_off"}, int'(offset), int'(eo));
        chk({tag, "_perf"}, int'(perfect), pf);
        chk({tag, "_busy"}, int'(busy), 0);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;

        // on-time press
        step(1, 0, 0);
        ticks(8, 0);
        wait_hit("ontime", 0, 1);

        // early and late presses
        step(1, 0, 0);
        ticks(3, 0);
        wait_hit("early", -5, 0);
        chk("early_raw", int'(offset), 6'b111011);
        step(1, 0, 0);
        ticks(10, 0);
        wait_hit("late", 2, 1);

        // expiry, then a press while idle
        step(1, 0, 0);
        ticks(16, 0);
        step(0, 1, 0);
        chk("expire_miss", int'(miss), 1);
        chk("expire_busy", int'(busy), 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("idle_press", int'(hit), 0);
        step(0, 0, 0);

        // press edge coincident with the expiring tick
        step(1, 0, 0);
        ticks(15, 0);
        step(0, 1, 1);
        step(0, 0, 1);
        step(0, 1, 1);
        chk("edge_hit", int'(hit), 1);
        chk("edge_miss", int'(miss), 0);
        chk("edge_off", int'(offset), 8);
        chk("edge_perf", int'(perfect), 0);
        step(0, 0, 0);
        step(0, 0, 0);

        // button held from before open through the window
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        ticks(16, 1);
        step(0, 1, 1);
        chk("held_miss", int'(miss), 1);
        step(0, 0, 0);

        // re-open at cnt=4, perfect press, then reset mid-window
        step(1, 0, 0);
        ticks(4, 0);
        step(1, 0, 0);
        chk("reopen_miss", int'(miss), 1);
        chk("reopen_busy", int'(busy), 1);
        ticks(8, 0);
        wait_hit("reopen", 0, 1);
        step(1, 0, 0);
        ticks(3, 0);
        do_reset();
        chk("rst_busy", int'(busy), 0);
        step(0, 0, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 24) == 0,
                     $urandom_range(0, 2) == 0,
                     ($urandom_range(0, 7) == 0) ? !btn : btn);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/note_judge.md
# note_judge

Timing-judgement stage for one rhythm-game lane. It opens a hit window each time a note approaches the judgement line and measures the player's button press against the note's ideal time. It emits exactly one single-cycle result per note: either a hit, with a perfect/good grade and a signed offset, or a miss. Its o_Hit/o_Miss pulses drive the combo counter directly downstream.

## Interface
- WIN_TICKS, 8: half-width of the hit window in ticks; the note's ideal time is WIN_TICKS ticks after window open.
- PERF_TICKS, 2: a hit with |offset| <= PERF_TICKS is graded perfect; must be <= WIN_TICKS.
- CNT_W, 6: window counter width; 2*WIN_TICKS < 2^CNT_W is required.
- i_Clk  in  1  system clock.
- i_Rst  in  1  reset, asynchronous, active-low.
- i_Tick  in  1  one-cycle time-base strobe (e.g. 1 kHz), synchronous to i_Clk.
- i_NoteOpen  in  1  one-cycle pulse: a note enters its hit window.
- i_Btn  in  1  raw, debounced lane button level, asynchronous to i_Clk.
- o_Hit  out  1  one-cycle pulse: the current note was hit.
- o_Miss  out  1  one-cycle pulse: the current note was missed.
- o_Perfect  out  1  valid only while o_Hit=1; 1 = perfect, 0 = good.
- o_Offset  out  CNT_W  signed two's-complement offset (cnt - WIN_TICKS) of the most recent hit; held until the next hit.
- o_Busy  out  1  a hit window is open.

## Operation
- Button path: 2-FF synchronizer, then a previous-value register. Press edge = synced 1 while previous 0. Only rising edges count; a held button never re-triggers.
- States:
  - IDLE: o_Busy=0.
  - OPEN: o_Busy=1; the counter cnt counts i_Tick pulses from 0.
- IDLE:
  - i_NoteOpen moves to OPEN with cnt=0.
  - A press edge is ignored and produces no output, including a press in the same cycle as i_NoteOpen.
- OPEN, evaluated each cycle in the following priority order:
  1. Press edge: o_Hit next cycle. offset = cnt - WIN_TICKS, computed at CNT_W bits signed. o_Perfect = (|offset| <= PERF_TICKS). o_Offset is loaded with offset. Then go to IDLE, unless i_NoteOpen is also present, in which case stay in OPEN with cnt=0.
  2. Otherwise, i_Tick with cnt == 2*WIN_TICKS: window expired. o_Miss next cycle, go to IDLE, unless i_NoteOpen is also present, in which case stay in OPEN with cnt=0.
  3. Otherwise, i_NoteOpen: the old note is a miss, so o_Miss next cycle; the new window starts with cnt=0.
  4. Otherwise, i_Tick: cnt increments by 1.
- o_Hit and o_Miss are never asserted together. Each window produces exactly one result pulse.
- cnt never exceeds 2*WIN_TICKS and never wraps.

## Timing
- Reset values: o_Hit=0, o_Miss=0, o_Perfect=0, o_Offset=0, o_Busy=0, state IDLE, cnt=0, synchronizer and edge registers 0.
- Reset is asynchronous. Asserting it mid-window aborts the note with no result pulse. After release, the block is in IDLE.
- i_Btn rise to press edge: 2 or 3 cycles (synchronizer). Press edge to o_Hit: 1 cycle, registered. Total i_Btn-to-o_Hit latency is 3–4 cycles.
- Expiring tick, or miss-causing i_NoteOpen, to o_Miss: 1 cycle.
- o_Busy rises the cycle after an i_NoteOpen accepted in IDLE. It falls in the cycle o_Hit or o_Miss is asserted, unless a new window opened.
- o_Perfect is valid only in the o_Hit cycle and is 0 otherwise.
- o_Offset updates in the same cycle as o_Hit.
- All outputs are registered; there are no combinational input-to-output paths.
- Full window length is 2*WIN_TICKS+1 tick intervals: the expiry tick is the (2*WIN_TICKS+1)th tick after open.

## Test plan
- Defaults. i_NoteOpen, 8 ticks, then press → one o_Hit, o_Perfect=1, o_Offset=0, o_Busy low afterwards, no o_Miss.
- i_NoteOpen, 3 ticks, press → o_Hit, o_Perfect=0, o_Offset=-5 (6'b111011). Repeat with a press after 10 ticks → o_Perfect=1, o_Offset=+2.
- i_NoteOpen, then 17 ticks with no press → o_Miss exactly 1 cycle after the 17th tick, o_Busy=0. A later press produces nothing.
- Press edge and the 17th tick in the same cycle → o_Hit, o_Offset=+8, o_Perfect=0, no o_Miss.
- Press in IDLE, and the button held from before i_NoteOpen through the window → no o_Hit. o_Miss at expiry.
- Second i_NoteOpen at cnt=4 without a press → o_Miss 1 cycle later, o_Busy stays 1, new window cnt=0. A later perfect press → o_Hit. Then assert i_Rst mid-window → no pulses, all outputs 0.
